seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. Holds one 4-bit hex value per digit in an internal register file, cycles the digit selects one at a time, and drives the matching hex-decoded segment pattern. Anti-ghosting blanking is inserted at each digit change. It replaces the static switch-to-segment path, so all eight digits appear lit at once.

## Interface
Parameters:
- CLK_DIV, 4: clock cycles per digit slot; legal range ≥ 2.
- BLANK, 1: leading cycles of each slot with all digits off; legal range 0 ≤ BLANK < CLK_DIV.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst  in  1  reset; **synchronous and active-high**.
- wr_en  in  1  write strobe for the digit register file.
- wr_addr  in  3  digit index to write.
- wr_data  in  4  hex value to store.
- dig_en  in  8  per-digit enable; 0 means the digit stays dark during its slot.
- dp_mask  in  8  per-digit decimal point; 1 lights the dp.
- SEG  out  8  segments, active-low; SEG[7]=dp, SEG[6:0]=g..a.
- AN  out  8  digit selects, active-low one-hot; all-ones means all digits off.
- scan_idx  out  3  digit index that the current AN/SEG outputs belong to.
- frame_tick  out  1  one-cycle pulse at the start of the digit-0 slot.

## Operation
- State:
  - digit register file buf[0..7], 4 bits each.
  - div_cnt, counts 0..CLK_DIV-1.
  - idx, 3 bits.
  - Registered outputs: SEG, AN, scan_idx, frame_tick.
- Write:
  - When wr_en=1 at a rising edge, buf[wr_addr] ← wr_data.
  - A write is never blocked, including a write to the digit currently displayed.
- Divider:
  - div_cnt increments each cycle.
  - When div_cnt == CLK_DIV-1, div_cnt ← 0 and idx ← idx+1.
  - idx wraps from 7 to 0 modulo 8.
- Output register, every edge, computed from pre-edge state (div_cnt, idx, buf, dig_en, dp_mask):
  - If div_cnt < BLANK or dig_en[idx]=0: AN ← 8'hFF and SEG ← 8'hFF.
  - Otherwise: AN ← ~(8'b1 << idx), SEG[6:0] ← decode(buf[idx]), SEG[7] ← ~dp_mask[idx].
  - scan_idx ← idx.
  - frame_tick ← (idx==0 && div_cnt==0).
- Decode table, hex digit to SEG with dp off:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8.
  - 8:80, 9:98, A:88, B:83, C:C6, D:A1, E:86, F:8E.
- dig_en and dp_mask are sampled every cycle, not latched per slot. A change mid-slot takes effect on the next edge.

## Timing
- Reset, when rst=1 at an edge:
  - buf all 0, div_cnt=0, idx=0.
  - AN=8'hFF, SEG=8'hFF, scan_idx=0, frame_tick=0.
  - rst has priority over a simultaneous wr_en; that write is discarded.
  - Reset asserted mid-slot or mid-frame aborts the scan immediately. No partial-slot output follows.
- First edge after rst deasserts:
  - frame_tick=1, scan_idx=0.
  - AN/SEG are blanked if BLANK ≥ 1.
- Slot i occupies CLK_DIV consecutive output cycles:
  - the first BLANK cycles are dark;
  - the remaining CLK_DIV-BLANK cycles are lit.
- Full frame = 8·CLK_DIV cycles; frame_tick period = 8·CLK_DIV.
- Output latency: 1 cycle from internal state to pins. AN, SEG and scan_idx are always mutually consistent in the same cycle.
- Write-to-pin latency:
  - wr_en sampled at edge n lands in buf at edge n.
  - The output at edge n still uses the old value.
  - The new value appears at edge n+1 if digit wr_addr is lit then.
- BLANK=0: no dark cycles; AN changes directly from one one-hot value to the next.
- AN is never multi-hot in any cycle.

## Test plan
- Reset then free-run (CLK_DIV=4, BLANK=1):
  - scan_idx steps 0,0,0,0,1,… with period 4;
  - AN reads FF, FE, FE, FE, FF, FD, …;
  - frame_tick pulses every 32 cycles.
- Write digits 0..7 with values 1,2,…,8, dig_en=FF, dp_mask=00: lit cycles of slot i show SEG = decode(i+1), e.g. slot 0 shows F9 and slot 7 shows 80.
- dig_en=8'b1111_0111: slot 3 holds AN=FF and SEG=FF for all 4 cycles; all other slots are unaffected.
- dp_mask=8'h01 with buf[0]=0: slot 0 lit cycles show SEG=40, AN=FE.
- Write buf[2]=F during a lit slot-2 cycle: the following edge shows SEG changing from the old pattern to 8E, with AN=FB unchanged.
- Assert rst mid-slot-5 together with wr_en to addr 5:
  - the next output is AN=FF, SEG=FF, scan_idx=0;
  - buf[5] reads back 0 (its display shows C0 when lit).

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Scans eight hex digits onto a common-anode 7-segment display, one digit per CLK_DIV-cycle slot.
// Latency: one cycle from internal scan state to the registered AN/SEG/scan_idx/frame_tick pins.
// Backpressure: none; writes are accepted every cycle and the scan free-runs.
module seg7_scan_ctrl #(
   parameter int CLK_DIV = 4,   // cycles per digit slot, >= 2
   parameter int BLANK   = 1    // dark cycles at the start of each slot, 0 <= BLANK < CLK_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic [7:0] dig_en,
   input  logic [7:0] dp_mask,
   output logic [7:0] SEG,
   output logic [7:0] AN,
   output logic [2:0] scan_idx,
   output logic       frame_tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

   logic [3:0]    digit_buf [8];
   logic [CW-1:0] div_cnt;
   logic [2:0]    idx;

   logic          lit;
   logic [7:0]    an_nxt;
   logic [7:0]    seg_nxt;

   // Hex digit to active-low segments g..a, decimal point excluded.
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h18;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Digit register file; reset wins over a coincident write, writes are never stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            digit_buf[i] <= 4'h0;
         end
      end else if (wr_en) begin
         digit_buf[wr_addr] <= wr_data;
      end
   end

   // Slot divider and digit index; idx wraps naturally 7 -> 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         idx     <= 3'd0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         idx     <= idx + 3'd1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Next pin values from the current scan state; dark slots force both buses to all-ones.
   always_comb begin
      an_nxt  = 8'hFF;
      seg_nxt = 8'hFF;
      lit     = (div_cnt >= BLANK_END) && dig_en[idx];
      if (lit) begin
         an_nxt  = ~(8'h01 << idx);
         seg_nxt = {~dp_mask[idx], decode(digit_buf[idx])};
      end
   end

   // Output register; AN, SEG and scan_idx share one stage so they always agree.
   always_ff @(posedge clk) begin
      if (rst) begin
         AN         <= 8'hFF;
         SEG        <= 8'hFF;
         scan_idx   <= 3'd0;
         frame_tick <= 1'b0;
      end else begin
         AN         <= an_nxt;
         SEG        <= seg_nxt;
         scan_idx   <= idx;
         frame_tick <= (idx == 3'd0) && (div_cnt == '0);
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with CLK_DIV=4, BLANK=1.
// Table of hand-computed vectors from reset, then frame-level checks against a cycle-count model.
// Hand-written sequences cover the mid-slot write and the mid-slot reset.
module tb_seg7_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = 3'd0;
   logic [3:0] wr_data = 4'd0;
   logic [7:0] dig_en = 8'hFF;
   logic [7:0] dp_mask = 8'h00;
   logic [7:0] SEG;
   logic [7:0] AN;
   logic [2:0] scan_idx;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;

   // t = number of output edges since reset was released (first edge after release is t=0)
   int         t;
   logic [3:0] bufm [8];
   logic [7:0] dec7 [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   typedef struct {
      logic       rst;
      logic       we;
      logic [2:0] addr;
      logic [3:0] data;
      logic [7:0] dig;
      logic [7:0] dp;
      logic [7:0] an;
      logic [7:0] seg;
      logic [2:0] ix;
      logic       tk;
   } vec_t;

   vec_t tbl [16];

   seg7_scan_ctrl #(.CLK_DIV(4), .BLANK(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .dig_en     (dig_en),
      .dp_mask    (dp_mask),
      .SEG        (SEG),
      .AN         (AN),
      .scan_idx   (scan_idx),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got %h expected %h", name, t, act, exp);
      end
   endtask

   // Expected pins for output edge tt: slot = tt/4 mod 8, first cycle of each slot dark.
   task automatic model(input int tt, output logic [7:0] an, output logic [7:0] seg,
                        output logic [2:0] ix, output logic tk);
      int slot;
      int pos;
      logic [7:0] d;
      slot = (tt / 4) % 8;
      pos  = tt % 4;
      ix   = 3'(slot);
      tk   = (tt % 32) == 0;
      an   = 8'hFF;
      seg  = 8'hFF;
      if (pos >= 1 && dig_en[slot]) begin
         d   = dec7[bufm[slot]];
         an  = ~(8'h01 << slot);
         seg = {~dp_mask[slot], d[6:0]};
      end
   endtask

   // One clock edge with optional write, checked against the model.
   task automatic step(input logic we, input logic [2:0] a, input logic [3:0] d);
      logic [7:0] ean;
      logic [7:0] eseg;
      logic [2:0] eix;
      logic       etk;
      rst     = 1'b0;
      wr_en   = we;
      wr_addr = a;
      wr_data = d;
      model(t, ean, eseg, eix, etk);
      @(posedge clk);
      if (we) bufm[a] = d;
      #1;
      chk("an", AN, ean);
      chk("seg", SEG, eseg);
      chk("idx", {5'd0, scan_idx}, {5'd0, eix});
      chk("tick", {7'd0, frame_tick}, {7'd0, etk});
      t++;
      wr_en = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      //          rst   we    addr  data  dig_en dp_mask AN     SEG    idx   tick
      tbl[0]  = '{1'b1, 1'b1, 3'd3, 4'd7, 8'hFF, 8'h00, 8'hFF, 8'hFF, 3'd0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 3'd0, 4'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 3'd0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 3'd0, 4'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 3'd0, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 3'd0, 4'd1, 8'hFF, 8'h00, 8'hFE, 8'hC0, 3'd0, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 3'd0, 4'd0, 8'hFF, 8'h00, 8'hFE, 8'hF9, 3'd0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 3'd1, 4'd2, 8'hFF, 8'h00, 8'hFE, 8'hF9, 3'd0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 3'd0, 4'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 3'd1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 3'd0, 4'd0, 8'hFF, 8'h00, 8'hFD, 8'hA4, 3'd1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 3'd0, 4'd0, 8'hFD, 8'h00, 8'hFF, 8'hFF, 3'd1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 3'd0, 4'd0, 8'hFF, 8'h02, 8'hFD, 8'h24, 3'd1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 3'd0, 4'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 3'd2, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 3'd0, 4'd0, 8'hFF, 8'h00, 8'hFB, 8'hC0, 3'd2, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 3'd0, 4'd0, 8'hFF, 8'h00, 8'hFB, 8'hC0, 3'd2, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 3'd0, 4'd0, 8'hFF, 8'h00, 8'hFB, 8'hC0, 3'd2, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 3'd0, 4'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 3'd3, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 3'd0, 4'd0, 8'hFF, 8'h00, 8'hF7, 8'hC0, 3'd3, 1'b0};

      t = -2;
      for (int i = 0; i < 16; i++) begin
         rst     = tbl[i].rst;
         wr_en   = tbl[i].we;
         wr_addr = tbl[i].addr;
         wr_data = tbl[i].data;
         dig_en  = tbl[i].dig;
         dp_mask = tbl[i].dp;
         @(posedge clk);
         #1;
         chk("tbl_an", AN, tbl[i].an);
         chk("tbl_seg", SEG, tbl[i].seg);
         chk("tbl_idx", {5'd0, scan_idx}, {5'd0, tbl[i].ix});
         chk("tbl_tick", {7'd0, frame_tick}, {7'd0, tbl[i].tk});
         t++;
      end
      wr_en = 1'b0;

      // State left by the table: buf0=1, buf1=2, the reset-time write to digit 3 discarded.
      t = 14;
      for (int i = 0; i < 8; i++) bufm[i] = 4'd0;
      bufm[0] = 4'd1;
      bufm[1] = 4'd2;

      // Load 1..8 while scanning, then watch more than a full frame.
      for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 4'(i + 1));
      for (int i = 0; i < 40; i++) step(1'b0, 3'd0, 4'd0);

      // Digit 3 disabled for a whole frame.
      dig_en = 8'b1111_0111;
      for (int i = 0; i < 32; i++) step(1'b0, 3'd0, 4'd0);
      dig_en = 8'hFF;

      // Decimal point on digit 0 holding a zero.
      step(1'b1, 3'd0, 4'd0);
      dp_mask = 8'h01;
      for (int i = 0; i < 32; i++) step(1'b0, 3'd0, 4'd0);
      dp_mask = 8'h00;

      // Write digit 2 during its own lit slot: old pattern at this edge, 8E at the next.
      while ((t % 32) != 10) step(1'b0, 3'd0, 4'd0);
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hF;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      bufm[2] = 4'hF;
      chk("wr2_an_old", AN, 8'hFB);
      chk("wr2_seg_old", SEG, 8'hB0);
      t++;
      @(posedge clk);
      #1;
      chk("wr2_an_new", AN, 8'hFB);
      chk("wr2_seg_new", SEG, 8'h8E);
      t++;

      // Reset in the middle of slot 5 together with a write to digit 5.
      while ((t % 32) != 21) step(1'b0, 3'd0, 4'd0);
      rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'h9;
      @(posedge clk);
      #1;
      rst = 1'b0; wr_en = 1'b0;
      chk("rst_an", AN, 8'hFF);
      chk("rst_seg", SEG, 8'hFF);
      chk("rst_idx", {5'd0, scan_idx}, 8'd0);
      chk("rst_tick", {7'd0, frame_tick}, 8'd0);
      for (int i = 0; i < 8; i++) bufm[i] = 4'd0;
      t = 0;
      for (int i = 0; i < 21; i++) step(1'b0, 3'd0, 4'd0);
      @(posedge clk);
      #1;
      chk("rst_buf5_an", AN, 8'hDF);
      chk("rst_buf5_seg", SEG, 8'hC0);
      chk("rst_buf5_idx", {5'd0, scan_idx}, 8'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
